// File: rtl/udp_frame_tx.sv
// udp_frame_tx: single-stream Ethernet/IPv4/UDP frame sequencer feeding rgmii_tx byte by byte
module udp_frame_tx #(
    parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [31:0] SRC_IP      = 32'hC0A8_010A,
    parameter logic [31:0] DST_IP      = 32'hC0A8_0101,
    parameter logic [15:0] SRC_PORT    = 16'd5000,
    parameter logic [15:0] DST_PORT    = 16'd5000,
    parameter logic [7:0]  TTL         = 8'd64,
    parameter int          PAYLOAD_MAX = 1472,
    parameter int          IFG_BYTES   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] payload_len,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        done,
    output logic        underrun
);
    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] PRE  = 4'd1;
    localparam logic [3:0] SFD  = 4'd2;
    localparam logic [3:0] ETH  = 4'd3;
    localparam logic [3:0] IP   = 4'd4;
    localparam logic [3:0] UDP  = 4'd5;
    localparam logic [3:0] PAY  = 4'd6;
    localparam logic [3:0] PAD  = 4'd7;
    localparam logic [3:0] FCS  = 4'd8;
    localparam logic [3:0] IFG  = 4'd9;
    localparam logic [10:0] PL_MAX = 11'(PAYLOAD_MAX);

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    logic [3:0]   state, cur, nxt;
    logic [10:0]  cnt, lim, len_q, pad_n;
    logic [15:0]  id, csum, tot_len, udp_len, fold2;
    logic [16:0]  fold1;
    logic [19:0]  sum;
    logic [31:0]  crc;
    logic [335:0] hdr;
    logic [5:0]   hidx;
    logic [7:0]   hdr_b, byte_c;
    logic         go, last;

    // state/cnt name the byte leaving on the next edge; an accepted start acts as PRE byte 0
    assign go      = state == IDLE && start && !busy;
    assign cur     = go ? PRE : state;
    assign pad_n   = len_q < 11'd18 ? 11'd18 - len_q : 11'd0;
    assign tot_len = 16'(len_q) + 16'd28;
    assign udp_len = 16'(len_q) + 16'd8;
    assign sum     = 20'h4500 + 20'(tot_len) + 20'(id) + 20'h4000 + 20'({TTL, 8'h11})
                   + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0]) + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
    assign fold1   = 17'(sum[15:0]) + 17'(sum[19:16]);
    assign fold2   = fold1[15:0] + 16'(fold1[16]);
    assign hdr     = {DST_MAC, SRC_MAC, 16'h0800,
                      16'h4500, tot_len, id, 16'h4000, TTL, 8'h11, csum, SRC_IP, DST_IP,
                      SRC_PORT, DST_PORT, udp_len, 16'h0000};
    assign hidx    = cnt[5:0] + (cur == IP ? 6'd14 : cur == UDP ? 6'd34 : 6'd0);
    assign hdr_b   = hdr[(41 - int'(hidx)) * 8 +: 8];
    assign byte_c  = cur == PRE ? 8'h55 :
                     cur == SFD ? 8'hD5 :
                     (cur == ETH || cur == IP || cur == UDP) ? hdr_b :
                     cur == PAY ? (pl_valid ? pl_data : 8'h00) :
                     cur == FCS ? ~crc[8 * cnt[1:0] +: 8] : 8'h00;
    assign last    = cnt + 11'd1 == lim;

    always_comb begin
        lim = 11'd1;
        nxt = IDLE;
        case (cur)
            PRE:     begin lim = 11'd7;  nxt = SFD; end
            SFD:     nxt = ETH;
            ETH:     begin lim = 11'd14; nxt = IP; end
            IP:      begin lim = 11'd20; nxt = UDP; end
            UDP:     begin lim = 11'd8;  nxt = len_q != 11'd0 ? PAY : pad_n != 11'd0 ? PAD : FCS; end
            PAY:     begin lim = len_q;  nxt = pad_n != 11'd0 ? PAD : FCS; end
            PAD:     begin lim = pad_n;  nxt = FCS; end
            FCS:     begin lim = 11'd4;  nxt = IFG; end
            IFG:     lim = 11'(IFG_BYTES);
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 11'd0;
            len_q    <= 11'd0;
            id       <= 16'd0;
            csum     <= 16'd0;
            crc      <= 32'hFFFFFFFF;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            pl_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= last ? nxt : cur;
            cnt      <= last ? 11'd0 : cnt + 11'd1;
            if (go) len_q <= payload_len > PL_MAX ? PL_MAX : payload_len;
            // len_q is settled after the first PRE cycle, so the checksum is final well before IP
            if (state == PRE) csum <= ~fold2;
            crc      <= cur == IDLE ? 32'hFFFFFFFF :
                        (cur == ETH || cur == IP || cur == UDP || cur == PAY || cur == PAD) ? crc_byte(crc, byte_c) : crc;
            if (cur == IFG && last) id <= id + 16'd1;
            tx_data  <= byte_c;
            tx_valid <= cur != IDLE && cur != IFG;
            pl_ready <= (last ? nxt : cur) == PAY;
            busy     <= cur != IDLE;
            done     <= cur == IFG && last;
            underrun <= cur == PAY && !pl_valid;
        end
    end
endmodule

// File: tb/tb_udp_frame_tx.sv
// tb_udp_frame_tx: randomized frames checked cycle by cycle against a byte-list frame model
module tb_udp_frame_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [10:0] payload_len = 11'd0;
    logic [7:0]  pl_data = 8'h00;
    logic        pl_valid = 1'b0;
    logic        pl_ready, tx_valid, busy, done, underrun;
    logic [7:0]  tx_data;

    int n_cmp = 0;
    int n_bad = 0;
    int id_m = 0;
    logic       pv [0:1599];
    logic [7:0] pd [0:1599];
    logic [7:0] ef [$];
    logic [7:0] got [$];

    udp_frame_tx dut (
        .clk(clk), .rst(rst), .start(start), .payload_len(payload_len),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .done(done), .underrun(underrun)
    );

    always #4 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic fb;
        for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ d[b];
            c = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    task automatic push16(input int w);
        ef.push_back(8'(w >> 8));
        ef.push_back(8'(w));
    endtask

    // residue of the captured frame in the conventional (bit-reversed) form
    function automatic logic [31:0] residue();
        logic [31:0] c, r;
        c = 32'hFFFFFFFF;
        for (int i = 8; i < got.size(); i++) c = crc_upd(c, got[i]);
        for (int b = 0; b < 32; b++) r[b] = c[31 - b];
        return r;
    endfunction

    // mode 0: payload always valid, 1: bytes 10-12 missing, 2: random gaps
    task automatic run_frame(input int req, input int mode, input bit glitch);
        int l, pad, n, s;
        logic [31:0] c;
        l = req > 1472 ? 1472 : req;
        pad = l < 18 ? 18 - l : 0;
        for (int t = 0; t < 1600; t++) begin
            pv[t] = mode == 0 ? 1'b1 : mode == 1 ? !(t >= 60 && t <= 62) : ($urandom_range(0, 7) != 0);
            pd[t] = 8'($urandom);
        end
        ef = {};
        repeat (7) ef.push_back(8'h55);
        ef.push_back(8'hD5);
        push16('hFFFF); push16('hFFFF); push16('hFFFF);
        push16('h0200); push16('h0000); push16('h0001);
        push16('h0800);
        s = 'h4500 + 28 + l + id_m + 'h4000 + 'h4011 + 'hC0A8 + 'h010A + 'hC0A8 + 'h0101;
        while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
        push16('h4500); push16(28 + l); push16(id_m); push16('h4000); push16('h4011);
        push16(~s & 'hFFFF);
        push16('hC0A8); push16('h010A); push16('hC0A8); push16('h0101);
        push16(5000); push16(5000); push16(8 + l); push16(0);
        for (int k = 0; k < l; k++) ef.push_back(pv[50 + k] ? pd[50 + k] : 8'h00);
        repeat (pad) ef.push_back(8'h00);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < ef.size(); i++) c = crc_upd(c, ef[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) ef.push_back(c[8 * i +: 8]);
        n = ef.size();
        got = {};
        for (int t = 0; t <= n + 12; t++) begin
            start = (t == 0) || (glitch && t == 20);
            payload_len = t == 0 ? 11'(req) : 11'($urandom);
            pl_valid = pv[t];
            pl_data = pd[t];
            chk("tx_valid", {31'd0, tx_valid}, {31'd0, t >= 1 && t <= n});
            chk("tx_data", {24'd0, tx_data}, (t >= 1 && t <= n) ? {24'd0, ef[t - 1]} : 32'd0);
            chk("busy", {31'd0, busy}, {31'd0, t >= 1 && t <= n + 12});
            chk("done", {31'd0, done}, {31'd0, t == n + 12});
            chk("pl_ready", {31'd0, pl_ready}, {31'd0, t >= 50 && t < 50 + l});
            chk("underrun", {31'd0, underrun}, {31'd0, (t >= 51 && t < 51 + l) ? !pv[t - 1] : 1'b0});
            if (tx_valid) got.push_back(tx_data);
            @(posedge clk); #1;
        end
        start = 1'b0;
        id_m = (id_m + 1) & 'hFFFF;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
        chk("rst_done_underrun", {30'd0, done, underrun}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        // T1: abort a frame with a 4-cycle reset
        start = 1'b1;
        payload_len = 11'd40;
        pl_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (55) @(posedge clk);
        #1;
        chk("t1_mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t1_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_pl_ready", {31'd0, pl_ready}, 32'd0);
        chk("t1_tx_data", {24'd0, tx_data}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        pl_valid = 1'b0;
        @(posedge clk); #1;
        chk("t1_idle_after", {30'd0, tx_valid, busy}, 32'd0);
        id_m = 0;
        // T2: short frame, first after reset so ID must be 0
        run_frame(4, 0, 1'b0);
        chk("t2_frame_len", got.size(), 32'd72);
        chk("t2_total_len", {16'd0, got[24], got[25]}, 32'h0020);
        chk("t2_ip_csum", {16'd0, got[32], got[33]}, 32'hB771);
        chk("t2_udp_len", {16'd0, got[46], got[47]}, 32'h000C);
        chk("t2_residue", residue(), 32'hC704DD7B);
        // T4: clamp
        run_frame(2000, 2, 1'b0);
        chk("t4_frame_len", got.size(), 32'd1526);
        chk("t4_total_len", {16'd0, got[24], got[25]}, 32'h05DC);
        chk("t4_ip_id", {16'd0, got[26], got[27]}, 32'h0001);
        chk("t4_residue", residue(), 32'hC704DD7B);
        // T5: underrun on payload bytes 10-12
        run_frame(32, 1, 1'b0);
        chk("t5_frame_len", got.size(), 32'd86);
        chk("t5_gap_bytes", {8'd0, got[60], got[61], got[62]}, 32'd0);
        chk("t5_residue", residue(), 32'hC704DD7B);
        // T6: start pulse mid-frame ignored, then empty payload
        run_frame(20, 2, 1'b1);
        run_frame(0, 0, 1'b0);
        chk("t6_frame_len", got.size(), 32'd72);
        chk("t6_udp_len", {16'd0, got[46], got[47]}, 32'h0008);
        chk("t6_residue", residue(), 32'hC704DD7B);
        run_frame(17, 2, 1'b0);
        run_frame(18, 2, 1'b1);
        run_frame(19, 2, 1'b0);
        run_frame(1472, 0, 1'b0);
        for (int f = 0; f < 6; f++) run_frame(int'($urandom_range(0, 90)), 2, f[0]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
